// File: rtl/addsub_sign_pipe.sv
// addsub_sign_pipe: two-stage sign-magnitude mantissa add/sub with valid/ready handshake and tag.
module addsub_sign_pipe #(
  parameter int W    = 24,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_sub,
  input  logic            in_sa,
  input  logic            in_sb,
  input  logic [W-1:0]    in_ma,
  input  logic [W-1:0]    in_mb,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_sign,
  output logic [W-1:0]    out_mag,
  output logic            out_carry,
  output logic            out_zero,
  output logic [TAGW-1:0] out_tag
);
  logic            stall;
  logic            sb_eff;
  logic            a_ge;
  logic            v1;
  logic            big_sign;
  logic            eff_add;
  logic            a_eq;
  logic [W-1:0]    big_m;
  logic [W-1:0]    sml_m;
  logic [TAGW-1:0] tag1;
  logic [W:0]      sum;
  logic            sign_n;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign sb_eff   = in_sb ^ in_sub;
  assign a_ge     = in_ma >= in_mb;
  always_ff @(posedge clk) begin
    if (reset) begin
      v1       <= 1'b0;
      big_m    <= '0;
      sml_m    <= '0;
      big_sign <= 1'b0;
      eff_add  <= 1'b0;
      a_eq     <= 1'b0;
      tag1     <= '0;
    end else if (!stall) begin
      v1 <= in_valid;
      if (in_valid) begin
        big_m    <= a_ge ? in_ma : in_mb;
        sml_m    <= a_ge ? in_mb : in_ma;
        big_sign <= a_ge ? in_sa : sb_eff;
        eff_add  <= in_sa == sb_eff;
        a_eq     <= in_ma == in_mb;
        tag1     <= in_tag;
      end
    end
  end
  // big >= small after the swap, so the subtract never borrows out of bit W
  assign sum    = eff_add ? {1'b0, big_m} + {1'b0, sml_m} : {1'b0, big_m} - {1'b0, sml_m};
  assign sign_n = (~eff_add & a_eq) ? 1'b0 : big_sign;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_mag   <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
    end else if (!stall) begin
      out_valid <= v1;
      if (v1) begin
        out_sign  <= sign_n;
        out_mag   <= sum[W-1:0];
        out_carry <= eff_add & sum[W];
        out_zero  <= sum[W-1:0] == '0;
        out_tag   <= tag1;
      end
    end
  end
endmodule
